// File: rtl/bdcpu_mem_arbiter_if.sv
// Requester/memory bus of the bdcpu memory arbiter.
// The master side holds the two requesters and the memory model; the slave
// side is the arbiter itself, which answers requests and drives the memory
// strobes. When BDCPU_MEM_ARB_LOCK_EN is defined, lock0/lock1 are added.
interface bdcpu_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  req0, req1;
  logic                  we0, we1;
  logic [ADDR_WIDTH-1:0] addr0, addr1;
  logic [DATA_WIDTH-1:0] wdata0, wdata1;
  logic                  ack0, ack1;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            grant;
  logic                  busy;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_output_enable;
  logic                  mem_write_enable;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;
`ifdef BDCPU_MEM_ARB_LOCK_EN
  logic                  lock0, lock1;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
           lock0, lock1,
    input  ack0, ack1, rdata, grant, busy,
           mem_address, mem_output_enable, mem_write_enable, mem_wdata
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
           lock0, lock1,
    output ack0, ack1, rdata, grant, busy,
           mem_address, mem_output_enable, mem_write_enable, mem_wdata
  );
`else
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  ack0, ack1, rdata, grant, busy,
           mem_address, mem_output_enable, mem_write_enable, mem_wdata
  );
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output ack0, ack1, rdata, grant, busy,
           mem_address, mem_output_enable, mem_write_enable, mem_wdata
  );
`endif
endinterface

// File: rtl/bdcpu_mem_arbiter.sv
// Two-requester round-robin arbiter for the shared 16x8 program/data memory.
// Each transaction is IDLE -> ACCESS (strobe) -> ACK (ack pulse); all outputs
// are registered. Optional ownership locking is enabled by defining
// BDCPU_MEM_ARB_LOCK_EN.
module bdcpu_mem_arbiter #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input logic                 clock,
  input logic                 reset,
  bdcpu_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ACK    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_owner_q, last_owner_d;  // 1 = req1 was last granted
  logic                  owner_q, owner_d;            // current owner, 1 = req1
  logic                  lock_held_q, lock_held_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  oe_q, oe_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  lock_owner;  // lock input of the current owner
  logic                  locked;      // ownership retained in this IDLE cycle
  logic                  pick_valid;
  logic                  pick;        // winning requester, 1 = req1

`ifdef BDCPU_MEM_ARB_LOCK_EN
  assign lock_owner = owner_q ? bus.lock1 : bus.lock0;
`else
  assign lock_owner = 1'b0;
`endif
  assign locked = lock_held_q & lock_owner;

  // State and registered outputs, synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      owner_q      <= 1'b0;
      lock_held_q  <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      rdata_q      <= '0;
      grant_q      <= 2'b00;
      busy_q       <= 1'b0;
      addr_q       <= '0;
      oe_q         <= 1'b0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      owner_q      <= owner_d;
      lock_held_q  <= lock_held_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      rdata_q      <= rdata_d;
      grant_q      <= grant_d;
      busy_q       <= busy_d;
      addr_q       <= addr_d;
      oe_q         <= oe_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
    end
  end

  // Arbitration, next state and next registered outputs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path through
    // this block can leave a value unassigned and infer a latch.
    state_d      = state_q;
    last_owner_d = last_owner_q;
    owner_d      = owner_q;
    lock_held_d  = lock_held_q;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    rdata_d      = rdata_q;
    grant_d      = grant_q;
    busy_d       = busy_q;
    addr_d       = addr_q;
    oe_d         = oe_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    pick_valid   = 1'b0;
    pick         = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (locked) begin
          // Locked owner keeps the port; the other requester is ignored.
          pick       = owner_q;
          pick_valid = owner_q ? bus.req1 : bus.req0;
        end else begin
          lock_held_d = 1'b0;
          pick_valid  = bus.req0 | bus.req1;
          // On a tie the requester that was not served last wins.
          pick        = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;
        end
        if (pick_valid) begin
          state_d = ACCESS;
          owner_d = pick;
          if (!locked) last_owner_d = pick;
          grant_d = pick ? 2'b10 : 2'b01;
          busy_d  = 1'b1;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          we_d    = pick ? bus.we1    : bus.we0;
          oe_d    = pick ? ~bus.we1   : ~bus.we0;
        end
      end
      ACCESS: begin
        if (oe_q) rdata_d = bus.mem_rdata;
        oe_d        = 1'b0;
        we_d        = 1'b0;
        ack0_d      = ~owner_q;
        ack1_d      = owner_q;
        lock_held_d = lock_owner;
        state_d     = ACK;
      end
      ACK: begin
        grant_d = 2'b00;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ack0              = ack0_q;
  assign bus.ack1              = ack1_q;
  assign bus.rdata             = rdata_q;
  assign bus.grant             = grant_q;
  assign bus.busy              = busy_q;
  assign bus.mem_address       = addr_q;
  assign bus.mem_output_enable = oe_q;
  assign bus.mem_write_enable  = we_q;
  assign bus.mem_wdata         = wdata_q;

endmodule

// File: doc/bdcpu_mem_arbiter.md
Name: bdcpu_mem_arbiter

Overview:
- Shares the single external 16x8 program/data memory between two requesters: req0 (CPU memory interface side) and req1 (program loader / debug port).
- Each requester uses a req/ack handshake. The arbiter runs one single-access transaction at a time on the memory port and returns read data with the ack.
- Sits between the requesters and the memory, in place of direct memory wiring in the top level.

Parameters:
- ADDR_WIDTH, 4, memory address width.
- DATA_WIDTH, 8, memory data width.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- req0 / req1  input  1  access request from requester 0 / 1.
- we0 / we1  input  1  1 = write, 0 = read; held stable with req.
- addr0 / addr1  input  ADDR_WIDTH  access address; held stable with req.
- wdata0 / wdata1  input  DATA_WIDTH  write data; held stable with req.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata  output  DATA_WIDTH  read data; valid in the ack cycle.
- grant  output  2  one-hot current owner (bit0 = req0); 00 when idle.
- busy  output  1  high in ACCESS and ACK states.
- mem_address  output  ADDR_WIDTH  memory address.
- mem_output_enable  output  1  memory read strobe; memory drives mem_rdata combinationally.
- mem_write_enable  output  1  memory write strobe; memory captures on posedge.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data.

Behaviour:
- FSM states: IDLE -> ACCESS -> ACK -> IDLE. Every transaction is exactly 3 states. All outputs are registered.
- Reset values:
  - state = IDLE.
  - ack0 = ack1 = 0; grant = 00; busy = 0.
  - mem_output_enable = mem_write_enable = 0.
  - mem_address = 0; mem_wdata = 0; rdata = 0.
  - last_owner = 1, so req0 wins the first tie.
- IDLE:
  - If any req is high, choose the owner, latch its addr/we/wdata onto the mem_* outputs, assert the matching strobe and set grant. Next state is ACCESS.
  - If no req is high, stay in IDLE.
- Arbitration is round-robin:
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_owner wins.
  - last_owner updates when the grant is issued.
- ACCESS:
  - Strobes are high for exactly this one cycle.
  - Read: rdata <= mem_rdata at the closing edge.
  - Write: the memory captures mem_wdata at the closing edge.
  - At the closing edge, drop the strobes, pulse ack of the owner, and go to ACK.
- ACK:
  - ack is high for this one cycle; rdata stays valid and holds until the next read completes.
  - Next state is IDLE and grant clears to 00.
- Latency: req sampled high at edge N -> strobe cycle N+1 -> ack cycle N+2. Minimum spacing between back-to-back transactions is 3 cycles.
- Requester rule: deassert req at the edge where ack=1 is sampled. A req that is still high in the following IDLE cycle is a new transaction.
- A non-owner's req can be raised or held at any time. It waits and is never dropped.
- req falling before ack (protocol violation): the transaction in flight still completes and ack is still pulsed.
- Reset mid-operation: all state returns to reset values at the edge.
  - A write whose ACCESS cycle coincides with reset still lands in memory at that edge.
  - No ack is issued for it.
- Addresses beyond 2^ADDR_WIDTH-1 cannot occur; there is no wrap logic.

Optional Feature:
- Macro: BDCPU_MEM_ARB_LOCK_EN.
- Enabled:
  - Adds input ports lock0 and lock1 (1 bit each).
  - If the owner's lock is high when the FSM enters ACK, ownership is retained. In IDLE only that owner's req is considered and the other req is ignored.
  - Ownership is released in the first IDLE cycle where the owner's lock is low; normal round-robin resumes that cycle.
  - last_owner is not updated by locked re-grants.
- Disabled: the lock ports do not exist and behaviour is pure round-robin as above.

Test Plan:
1. Reset, then req0 write addr=0xE wdata=0x51 -> mem_write_enable high exactly 1 cycle with mem_address=0xE; ack0 pulses 2 cycles after req; memory[0xE]=0x51.
2. req1 read addr=0xE after step 1 -> mem_output_enable high 1 cycle; ack1 pulses with rdata=0x51; grant=10 during ACCESS/ACK.
3. req0 and req1 asserted together from reset, each holding req high and re-requesting until 2 acks each -> grant order 0,1,0,1; no ack overlap; transactions 3 cycles apart.
4. Reset asserted during the ACCESS cycle of a write to 0x3 with 0xAA -> memory[0x3]=0xAA; no ack; next cycle all outputs at reset values and state IDLE.
5. BDCPU_MEM_ARB_LOCK_EN: req0 with lock0=1 for 3 reads while req1 held high -> three consecutive ack0 with no ack1; drop lock0 -> next grant goes to req1.
6. req0 read of addr 0x0 holding 0x00 while mem_rdata changes outside ACCESS -> rdata=0x00 and stable through ACK and beyond, until the next read.
